// File: rtl/rca_seq_responder.sv
// rca_seq_responder: adder responder; accepts (a, b, cin), returns a + b + cin
// computed CHUNK bits per cycle by a single ripple-carry slice.
// Latency: accept at edge E -> rsp_valid high after edge E + N/CHUNK.
// Backpressure: req_ready low while busy; result held in DONE until rsp_ready.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready operand request handshake (a, b, cin sampled on accept)
//   rsp_valid/rsp_ready result handshake (sum, cout stable while rsp_valid)
//   busy                high in CALC or DONE
//   txn_cnt             completed response handshakes, wraps at 2^CW
module rca_seq_responder #(
  parameter int N     = 4,
  parameter int CHUNK = 1,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          cin,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  sum,
  output logic          cout,
  output logic          busy,
  output logic [CW-1:0] txn_cnt
);

  // Guard against a zero divisor so an illegal CHUNK reaches the check below
  // instead of failing inside a constant expression.
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int STEPS      = N / CHUNK_SAFE;
  localparam int IDX_W      = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SW         = CHUNK_SAFE + 1;   // slice adder width incl. carry

  if (CHUNK < 1 || CHUNK > N || (N % CHUNK_SAFE) != 0) begin : g_bad_params
    $error("rca_seq_responder: CHUNK must satisfy 1 <= CHUNK <= N and divide N");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic [CW-1:0]   txn_q, txn_d;

  logic [CHUNK_SAFE-1:0] slice_a;
  logic [CHUNK_SAFE-1:0] slice_b;
  logic [SW-1:0]         slice_res;
  logic                  last_step;

  // Handshake and status outputs are pure decodes of the state register.
  // req_ready also drops during reset so a request is never taken then.
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign txn_cnt   = txn_q;

  // Operand slice select. Written as a compare-per-step mux so every
  // part-select has a constant base.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (idx_q == IDX_W'(s)) begin
        slice_a = a_q[s*CHUNK_SAFE +: CHUNK_SAFE];
        slice_b = b_q[s*CHUNK_SAFE +: CHUNK_SAFE];
      end
    end
  end

  // One ripple-carry slice; bit CHUNK is the carry into the next slice.
  assign slice_res = SW'(slice_a) + SW'(slice_b) + SW'(carry_q);
  assign last_step = (idx_q == IDX_W'(STEPS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    txn_d   = txn_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        for (int s = 0; s < STEPS; s++) begin
          if (idx_q == IDX_W'(s)) begin
            sum_d[s*CHUNK_SAFE +: CHUNK_SAFE] = slice_res[CHUNK_SAFE-1:0];
          end
        end
        carry_d = slice_res[CHUNK_SAFE];
        if (last_step) begin
          cout_d  = slice_res[CHUNK_SAFE];
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        // Result registers are not touched here, so sum/cout hold while
        // the consumer stalls. A concurrent request waits for IDLE.
        if (rsp_ready) begin
          txn_d   = txn_q + CW'(1);
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      txn_q   <= txn_d;
    end
  end

endmodule

// File: tb/tb_rca_seq_responder.sv
// tb_rca_seq_responder: checks three responders (CHUNK = 1, 2, 4 at N = 4)
// against constant vectors, hand-built corner sequences and an arithmetic
// model over all 512 operand combinations with random response stalls.
module tb_rca_seq_responder;

  localparam int NI = 3;   // instance k uses CHUNK = 1 << k

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid_s [NI];
  logic        req_ready_s [NI];
  logic [3:0]  a_s         [NI];
  logic [3:0]  b_s         [NI];
  logic        cin_s       [NI];
  logic        rsp_valid_s [NI];
  logic        rsp_ready_s [NI];
  logic [3:0]  sum_s       [NI];
  logic        cout_s      [NI];
  logic        busy_s      [NI];
  logic [15:0] txn_s       [NI];

  int n_vec = 0;
  int n_err = 0;
  int exp_txn [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rca_seq_responder #(.N(4), .CHUNK(1 << g), .CW(16)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid_s[g]),
      .req_ready (req_ready_s[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .cin       (cin_s[g]),
      .rsp_valid (rsp_valid_s[g]),
      .rsp_ready (rsp_ready_s[g]),
      .sum       (sum_s[g]),
      .cout      (cout_s[g]),
      .busy      (busy_s[g]),
      .txn_cnt   (txn_s[g])
    );
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       co;
  } vec_t;

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL inst%0d %s: got %0h expected %0h (t=%0t)", k, nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NI; k++) exp_txn[k] = 0;
  endtask

  task automatic scramble(input int k);
    a_s[k]         = 4'($urandom);
    b_s[k]         = 4'($urandom);
    cin_s[k]       = 1'($urandom);
    req_valid_s[k] = 1'($urandom);
  endtask

  // Wait (bounded) for rsp_valid while junk is driven on the request side
  // and rsp_ready toggles; returns the number of edges waited.
  task automatic wait_rsp(input int k, output int cyc);
    cyc = 0;
    while (rsp_valid_s[k] !== 1'b1 && cyc < 20) begin
      scramble(k);
      rsp_ready_s[k] = 1'($urandom);
      tick();
      cyc++;
    end
    rsp_ready_s[k] = 1'b0;
  endtask

  // Full transaction: accept, latency, hold under stall, handshake, counter.
  task automatic do_txn(input int k, input logic [3:0] ta, input logic [3:0] tbv,
                        input logic tc, input int gap, input logic [3:0] es,
                        input logic eco);
    int cyc;
    cyc = 0;
    while (req_ready_s[k] !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("req_ready_idle", k, 32'(req_ready_s[k]), 1);
    a_s[k] = ta; b_s[k] = tbv; cin_s[k] = tc; req_valid_s[k] = 1'b1;
    tick();
    req_valid_s[k] = 1'b0;
    wait_rsp(k, cyc);
    chk("latency", k, cyc, 4 >> k);
    repeat (gap) begin
      scramble(k);
      tick();
    end
    chk("sum", k, 32'(sum_s[k]), 32'(es));
    chk("cout", k, 32'(cout_s[k]), 32'(eco));
    chk("rsp_valid_hold", k, 32'(rsp_valid_s[k]), 1);
    rsp_ready_s[k] = 1'b1;
    req_valid_s[k] = 1'($urandom);   // a request alongside the handshake must wait
    tick();
    rsp_ready_s[k] = 1'b0;
    req_valid_s[k] = 1'b0;
    exp_txn[k]++;
    chk("txn_cnt", k, 32'(txn_s[k]), exp_txn[k]);
    chk("busy_after_rsp", k, 32'(busy_s[k]), 0);
    chk("rsp_valid_after_rsp", k, 32'(rsp_valid_s[k]), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [6];
    int   cyc;
    logic [8:0] v;
    logic [4:0] tot;

    tbl[0] = '{a: 4'h3, b: 4'h5, cin: 1'b0, s: 4'h8, co: 1'b0};
    tbl[1] = '{a: 4'hF, b: 4'h1, cin: 1'b0, s: 4'h0, co: 1'b1};
    tbl[2] = '{a: 4'hF, b: 4'hF, cin: 1'b1, s: 4'hF, co: 1'b1};
    tbl[3] = '{a: 4'h0, b: 4'h0, cin: 1'b1, s: 4'h1, co: 1'b0};
    tbl[4] = '{a: 4'hA, b: 4'h5, cin: 1'b1, s: 4'h0, co: 1'b1};
    tbl[5] = '{a: 4'h6, b: 4'h2, cin: 1'b0, s: 4'h8, co: 1'b0};

    for (int k = 0; k < NI; k++) begin
      rsp_ready_s[k] = 1'b0;
      scramble(k);
      req_valid_s[k] = 1'b1;
    end
    clear_model();

    // Reset held two cycles with live requests: nothing may be accepted.
    rst = 1'b1;
    repeat (2) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        chk("rst_req_ready", k, 32'(req_ready_s[k]), 0);
        chk("rst_busy", k, 32'(busy_s[k]), 0);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < NI; k++) req_valid_s[k] = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("post_rst_req_ready", k, 32'(req_ready_s[k]), 1);
      chk("post_rst_rsp_valid", k, 32'(rsp_valid_s[k]), 0);
      chk("post_rst_sum", k, 32'(sum_s[k]), 0);
      chk("post_rst_cout", k, 32'(cout_s[k]), 0);
      chk("post_rst_txn", k, 32'(txn_s[k]), 0);
    end

    // Constant vectors on the CHUNK=1 instance.
    for (int i = 0; i < 6; i++)
      do_txn(0, tbl[i].a, tbl[i].b, tbl[i].cin, $urandom_range(0, 2), tbl[i].s, tbl[i].co);

    // Long stall in DONE with request-side noise; then a request issued in
    // the same cycle as the handshake is taken only on the following edge.
    a_s[0] = 4'hA; b_s[0] = 4'h6; cin_s[0] = 1'b1; req_valid_s[0] = 1'b1;
    tick();
    req_valid_s[0] = 1'b0;
    wait_rsp(0, cyc);
    chk("bp_latency", 0, cyc, 4);
    repeat (10) begin
      scramble(0);
      tick();
      chk("bp_rsp_valid", 0, 32'(rsp_valid_s[0]), 1);
      chk("bp_sum", 0, 32'(sum_s[0]), 32'h1);
      chk("bp_cout", 0, 32'(cout_s[0]), 1);
      chk("bp_req_ready", 0, 32'(req_ready_s[0]), 0);
    end
    a_s[0] = 4'h2; b_s[0] = 4'h3; cin_s[0] = 1'b0;
    req_valid_s[0] = 1'b1; rsp_ready_s[0] = 1'b1;
    tick();
    rsp_ready_s[0] = 1'b0;
    exp_txn[0]++;
    chk("simul_busy", 0, 32'(busy_s[0]), 0);
    chk("simul_req_ready", 0, 32'(req_ready_s[0]), 1);
    chk("simul_txn", 0, 32'(txn_s[0]), exp_txn[0]);
    tick();
    req_valid_s[0] = 1'b0;
    chk("simul_accept_next", 0, 32'(busy_s[0]), 1);
    wait_rsp(0, cyc);
    chk("simul_sum", 0, 32'(sum_s[0]), 32'h5);
    chk("simul_cout", 0, 32'(cout_s[0]), 0);
    rsp_ready_s[0] = 1'b1;
    tick();
    rsp_ready_s[0] = 1'b0;
    exp_txn[0]++;
    chk("simul_txn2", 0, 32'(txn_s[0]), exp_txn[0]);

    // Reset during the second CALC cycle aborts the transaction.
    a_s[0] = 4'h3; b_s[0] = 4'h3; cin_s[0] = 1'b0; req_valid_s[0] = 1'b1;
    tick();
    req_valid_s[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    repeat (6) begin
      tick();
      chk("abort_rsp_valid", 0, 32'(rsp_valid_s[0]), 0);
      chk("abort_busy", 0, 32'(busy_s[0]), 0);
    end
    chk("abort_txn", 0, 32'(txn_s[0]), 0);
    do_txn(0, 4'h7, 4'h9, 1'b0, 1, 4'h0, 1'b1);

    // Reset while DONE with rsp_ready high: no completion is counted.
    a_s[0] = 4'h1; b_s[0] = 4'h1; cin_s[0] = 1'b0; req_valid_s[0] = 1'b1;
    tick();
    req_valid_s[0] = 1'b0;
    wait_rsp(0, cyc);
    rst = 1'b1; rsp_ready_s[0] = 1'b1;
    tick();
    rst = 1'b0; rsp_ready_s[0] = 1'b0;
    clear_model();
    #1;
    chk("done_rst_rsp_valid", 0, 32'(rsp_valid_s[0]), 0);
    chk("done_rst_txn", 0, 32'(txn_s[0]), 0);
    chk("done_rst_req_ready", 0, 32'(req_ready_s[0]), 1);

    // Every (a, b, cin) on every CHUNK setting against plain arithmetic.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 512; i++) begin
        v   = 9'(i);
        tot = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
        do_txn(k, v[3:0], v[7:4], v[8], $urandom_range(0, 2), tot[3:0], tot[4]);
      end
      chk("txn_total", k, 32'(txn_s[k]), 512);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
